ncl_mult3_sync_driver: RTL and testbench

Clocked bridge between a synchronous valid/ready host and the asynchronous dual-rail NCL 3×3 multiplier core. It encodes a pair of 3-bit binary operands into a dual-rail DATA wavefront, then waits for the core's acknowledge (Ko) and for a complete dual-rail product. It then decodes and buffers the 6-bit product, sequences the NULL wavefront, and drives the core's output-side request (Ki), acting as both the source and the sink of the core's four-phase handshake.

---
 rtl/ncl_mult3_sync_driver_if.sv | 32 +++
 rtl/ncl_mult3_sync_driver.sv | 180 ++++++++++++++++++
 tb/tb_ncl_mult3_sync_driver.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ncl_mult3_sync_driver_if.sv
// Host-side and NCL-core-side signal bundle for ncl_mult3_sync_driver.
// slave: the driver itself; master: the host together with the core.
interface ncl_mult3_sync_driver_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] a;
    logic [2:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] p;
    logic       err;
    logic [2:0] a_rail1;
    logic [2:0] a_rail0;
    logic [2:0] b_rail1;
    logic [2:0] b_rail0;
    logic       ki;
    logic       ko;
    logic [5:0] p_rail1;
    logic [5:0] p_rail0;

    modport slave (
        input  in_valid, a, b, out_ready, ko, p_rail1, p_rail0,
        output in_ready, out_valid, p, err,
        output a_rail1, a_rail0, b_rail1, b_rail0, ki
    );

    modport master (
        output in_valid, a, b, out_ready, ko, p_rail1, p_rail0,
        input  in_ready, out_valid, p, err,
        input  a_rail1, a_rail0, b_rail1, b_rail0, ki
    );
endinterface

// File: rtl/ncl_mult3_sync_driver.sv
// Valid/ready bridge that sources and sinks the NCL 3x3 multiplier handshake.
// Define NCL_MULT3_DRV_RAILCHECK_EN to fault on persistent both-rails-high bits.
module ncl_mult3_sync_driver #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                    clk,
    input logic                    rst,
    ncl_mult3_sync_driver_if.slave bus
);
    localparam int CW =
        (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_NULL,
        S_ERR
    } state_e;

    state_e        state_q, state_d;
    logic [12:0]   sync_q [SYNC_STAGES];
    logic          ko_s;
    logic [5:0]    pr1_s, pr0_s;
    logic [11:0]   pat_q, pat_d;
    logic          hold_q, hold_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]    a1_q, a1_d, a0_q, a0_d;
    logic [2:0]    b1_q, b1_d, b0_q, b0_d;
    logic          ki_q, ki_d;
    logic          ov_q, ov_d;
    logic          err_q, err_d;
    logic [5:0]    p_q, p_d;
    logic          in_ready_w, accept;
    logic          data_ok, null_ok, same_pat;
    logic          tmo, fault_rail;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {bus.ko, bus.p_rail1, bus.p_rail0};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {ko_s, pr1_s, pr0_s} = sync_q[SYNC_STAGES-1];

`ifdef NCL_MULT3_DRV_RAILCHECK_EN
    logic bad_q;
    always_ff @(posedge clk) begin
        if (rst) bad_q <= 1'b0;
        else     bad_q <= |(pr1_s & pr0_s);
    end
    assign fault_rail = bad_q && (|(pr1_s & pr0_s));
`else
    assign fault_rail = 1'b0;
`endif

    // A bit with both rails high is never counted as complete.
    assign data_ok  = !ko_s && (&(pr1_s ^ pr0_s));
    assign null_ok  = ko_s && !(|{pr1_s, pr0_s});
    assign same_pat = ({pr1_s, pr0_s} == pat_q);
    assign cnt_inc  = cnt_q + CW'(1);
    assign tmo      = (TIMEOUT_CYCLES != 0) && (cnt_inc == TMO);

    assign in_ready_w = (state_q == S_IDLE) && !rst
                     && (!ov_q || bus.out_ready);
    assign accept     = bus.in_valid && in_ready_w;

    always_comb begin
        state_d = state_q;
        pat_d   = {pr1_s, pr0_s};
        hold_d  = 1'b0;
        cnt_d   = cnt_q;
        a1_d    = a1_q;
        a0_d    = a0_q;
        b1_d    = b1_q;
        b0_d    = b0_q;
        ki_d    = ki_q;
        ov_d    = ov_q;
        err_d   = err_q;
        p_d     = p_q;
        if (ov_q && bus.out_ready) ov_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a1_d    = bus.a;
                    a0_d    = ~bus.a;
                    b1_d    = bus.b;
                    b0_d    = ~bus.b;
                    ki_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                hold_d = data_ok;
                cnt_d  = cnt_inc;
                if (data_ok && hold_q && same_pat) begin
                    p_d     = pr1_s;
                    ov_d    = 1'b1;
                    a1_d    = '0;
                    a0_d    = '0;
                    b1_d    = '0;
                    b0_d    = '0;
                    ki_d    = 1'b0;
                    hold_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_NULL;
                end else if (tmo || fault_rail) begin
                    state_d = S_ERR;
                end
            end
            S_NULL: begin
                hold_d = null_ok;
                cnt_d  = cnt_inc;
                if (null_ok && hold_q) begin
                    ki_d    = 1'b1;
                    hold_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (tmo || fault_rail) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                hold_d = 1'b0;
            end
        endcase
        if (state_d == S_ERR) begin
            a1_d  = '0;
            a0_d  = '0;
            b1_d  = '0;
            b0_d  = '0;
            ki_d  = 1'b0;
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            hold_q  <= 1'b0;
            cnt_q   <= '0;
            a1_q    <= '0;
            a0_q    <= '0;
            b1_q    <= '0;
            b0_q    <= '0;
            ki_q    <= 1'b1;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            a1_q    <= a1_d;
            a0_q    <= a0_d;
            b1_q    <= b1_d;
            b0_q    <= b0_d;
            ki_q    <= ki_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
            p_q     <= p_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = ov_q;
    assign bus.p         = p_q;
    assign bus.err       = err_q;
    assign bus.a_rail1   = a1_q;
    assign bus.a_rail0   = a0_q;
    assign bus.b_rail1   = b1_q;
    assign bus.b_rail0   = b0_q;
    assign bus.ki        = ki_q;
endmodule

// File: tb/tb_ncl_mult3_sync_driver.sv
// Directed bench for ncl_mult3_sync_driver with a behavioural NCL core.
// The core is either an ideal 3-cycle model or driven by hand per test.
module tb_ncl_mult3_sync_driver;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   mode     = 0;
    int   hs_cnt   = 0;

    logic       t_ko = 1'b1;
    logic [5:0] t_p1 = '0;
    logic [5:0] t_p0 = '0;
    logic       m_ko;
    logic [5:0] m_p1, m_p0;
    int         dly;

    ncl_mult3_sync_driver_if bus ();

    ncl_mult3_sync_driver #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.ko      = (mode == 0) ? m_ko : t_ko;
    assign bus.p_rail1 = (mode == 0) ? m_p1 : t_p1;
    assign bus.p_rail0 = (mode == 0) ? m_p0 : t_p0;

    logic       in_data, in_null;
    logic [5:0] prod;
    assign in_data = (&(bus.a_rail1 ^ bus.a_rail0))
                  && (&(bus.b_rail1 ^ bus.b_rail0));
    assign in_null = !(|{bus.a_rail1, bus.a_rail0,
                         bus.b_rail1, bus.b_rail0});
    assign prod = {3'b000, bus.a_rail1} * {3'b000, bus.b_rail1};

    // Ideal core: answers each wavefront three cycles after it arrives.
    always @(posedge clk) begin
        if (rst || mode != 0) begin
            m_ko <= 1'b1;
            m_p1 <= '0;
            m_p0 <= '0;
            dly  <= 0;
        end else if (m_ko && in_data) begin
            if (dly == 2) begin
                m_ko <= 1'b0;
                m_p1 <= prod;
                m_p0 <= ~prod;
                dly  <= 0;
            end else dly <= dly + 1;
        end else if (!m_ko && in_null) begin
            if (dly == 2) begin
                m_ko <= 1'b1;
                m_p1 <= '0;
                m_p0 <= '0;
                dly  <= 0;
            end else dly <= dly + 1;
        end else dly <= 0;
    end

    always @(posedge clk)
        if (!rst && bus.out_valid && bus.out_ready) hs_cnt <= hs_cnt + 1;

    task automatic send(input logic [2:0] x, input logic [2:0] y);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = x;
        bus.b = y;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout: in_ready=%b want 1", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ov();
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ov_timeout: out_valid=%b want 1", bus.out_valid);
        end
    endtask

    task automatic wait_ki();
        int n = 0;
        while (bus.ki !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.ki !== 1'b1) begin
            failures++;
            $display("FAIL ki_timeout: ki=%b want 1", bus.ki);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.ki !== 1'b1 ||
            bus.out_valid !== 1'b0 || bus.err !== 1'b0 ||
            bus.p !== 6'd0) begin
            failures++;
            $display("FAIL reset_flags: ir=%b ki=%b ov=%b err=%b p=%0d want 0 1 0 0 0",
                     bus.in_ready, bus.ki, bus.out_valid, bus.err, bus.p);
        end
        checks++;
        if ({bus.a_rail1, bus.a_rail0, bus.b_rail1, bus.b_rail0} !== 12'd0) begin
            failures++;
            $display("FAIL reset_rails: got %b want 0",
                     {bus.a_rail1, bus.a_rail0, bus.b_rail1, bus.b_rail0});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b0;
        send(3'd5, 3'd7);
        checks++;
        if (bus.a_rail1 !== 3'b101 || bus.a_rail0 !== 3'b010 ||
            bus.b_rail1 !== 3'b111 || bus.b_rail0 !== 3'b000) begin
            failures++;
            $display("FAIL basic_rails: a=%b/%b b=%b/%b want 101/010 111/000",
                     bus.a_rail1, bus.a_rail0, bus.b_rail1, bus.b_rail0);
        end
        wait_ov();
        checks++;
        if (bus.p !== 6'b100011) begin
            failures++;
            $display("FAIL basic_p: got %0d want 35", bus.p);
        end
        checks++;
        if (bus.ki !== 1'b0 || bus.a_rail1 !== 3'd0 || bus.b_rail0 !== 3'd0) begin
            failures++;
            $display("FAIL basic_null_launch: ki=%b a1=%b b0=%b want 0 0 0",
                     bus.ki, bus.a_rail1, bus.b_rail0);
        end
        bus.out_ready = 1'b1;
        wait_ki();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle: ir=%b ov=%b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        int bad = 0;
        logic [5:0] v;
        bus.out_ready = 1'b1;
        start = hs_cnt;
        for (int i = 0; i < 64; i++) begin
            v = i[5:0];
            send(v[5:3], v[2:0]);
            wait_ov();
            checks++;
            if (bus.p !== 6'(int'(v[5:3]) * int'(v[2:0]))) begin
                failures++;
                bad++;
                $display("FAIL sweep_p: a=%0d b=%0d got %0d want %0d",
                         v[5:3], v[2:0], bus.p, int'(v[5:3]) * int'(v[2:0]));
            end
        end
        @(negedge clk);
        checks++;
        if (hs_cnt - start !== 64) begin
            failures++;
            $display("FAIL sweep_count: got %0d results want 64", hs_cnt - start);
        end
        checks++;
        if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL sweep_err: got %b want 0", bus.err);
        end
        wait_ki();
    endtask

    task automatic test_backpressure();
        bit stable = 1'b1;
        bus.out_ready = 1'b0;
        send(3'd7, 3'd7);
        wait_ov();
        bus.in_valid = 1'b1;
        bus.a = 3'd1;
        bus.b = 3'd1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.p !== 6'd49 || bus.out_valid !== 1'b1) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL bp_hold: p=%0d ov=%b want 49 1", bus.p, bus.out_valid);
        end
        checks++;
        if (bus.ki !== 1'b1) begin
            failures++;
            $display("FAIL bp_null_done: ki=%b want 1", bus.ki);
        end
        checks++;
        if (bus.in_ready !== 1'b0 || bus.a_rail1 !== 3'd0) begin
            failures++;
            $display("FAIL bp_blocked: ir=%b a1=%b want 0 000",
                     bus.in_ready, bus.a_rail1);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.a_rail1 !== 3'b001 ||
            bus.b_rail0 !== 3'b110) begin
            failures++;
            $display("FAIL bp_consume_accept: ov=%b a1=%b b0=%b want 0 001 110",
                     bus.out_valid, bus.a_rail1, bus.b_rail0);
        end
        wait_ov();
        checks++;
        if (bus.p !== 6'd1) begin
            failures++;
            $display("FAIL bp_next_p: got %0d want 1", bus.p);
        end
        wait_ki();
    endtask

    task automatic test_glitch();
        bus.out_ready = 1'b1;
        t_ko = 1'b1;
        t_p1 = '0;
        t_p0 = '0;
        mode = 1;
        send(3'd1, 3'd2);
        repeat (2) @(negedge clk);
        t_ko = 1'b0;
        t_p1 = 6'b000110;
        t_p0 = 6'b111001;
        @(negedge clk);
        t_p1 = 6'b000010;
        t_p0 = 6'b111101;
        wait_ov();
        checks++;
        if (bus.p !== 6'd2) begin
            failures++;
            $display("FAIL glitch_p: got %0d want 2", bus.p);
        end
        t_ko = 1'b1;
        t_p1 = '0;
        t_p0 = '0;
        wait_ki();
        mode = 0;
    endtask

    task automatic test_railcheck();
        bus.out_ready = 1'b1;
        t_ko = 1'b1;
        t_p1 = '0;
        t_p0 = '0;
        mode = 1;
        send(3'd3, 3'd1);
        t_ko = 1'b0;
        t_p1 = 6'b000011;
        t_p0 = 6'b111101;
        repeat (3) @(negedge clk);
`ifdef NCL_MULT3_DRV_RAILCHECK_EN
        repeat (3) @(negedge clk);
        checks++;
        if (bus.err !== 1'b1 || bus.ki !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.a_rail1 !== 3'd0 || bus.a_rail0 !== 3'd0) begin
            failures++;
            $display("FAIL rail_fault: err=%b ki=%b ir=%b a=%b/%b want 1 0 0 0/0",
                     bus.err, bus.ki, bus.in_ready, bus.a_rail1, bus.a_rail0);
        end
        t_ko = 1'b1;
        t_p1 = '0;
        t_p0 = '0;
        mode = 0;
        test_reset();
`else
        repeat (7) @(negedge clk);
        checks++;
        if (bus.err !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rail_stall: err=%b ov=%b want 0 0",
                     bus.err, bus.out_valid);
        end
        t_p0 = 6'b111100;
        wait_ov();
        checks++;
        if (bus.p !== 6'd3) begin
            failures++;
            $display("FAIL rail_recover_p: got %0d want 3", bus.p);
        end
        t_ko = 1'b1;
        t_p1 = '0;
        t_p0 = '0;
        wait_ki();
        mode = 0;
`endif
    endtask

    task automatic test_timeout();
        bus.out_ready = 1'b1;
        t_ko = 1'b1;
        t_p1 = '0;
        t_p0 = '0;
        mode = 1;
        send(3'd2, 3'd3);
        repeat (63) @(negedge clk);
        checks++;
        if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL tmo_early: err=%b want 0 after 63 cycles", bus.err);
        end
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b1 || bus.ki !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.a_rail1 !== 3'd0 || bus.b_rail0 !== 3'd0) begin
            failures++;
            $display("FAIL tmo_fault: err=%b ki=%b ir=%b a1=%b b0=%b want 1 0 0 0 0",
                     bus.err, bus.ki, bus.in_ready, bus.a_rail1, bus.b_rail0);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (bus.err !== 1'b1) begin
            failures++;
            $display("FAIL tmo_sticky: err=%b want 1", bus.err);
        end
        mode = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.err !== 1'b0 || bus.ki !== 1'b1) begin
            failures++;
            $display("FAIL tmo_reset: err=%b ki=%b want 0 1", bus.err, bus.ki);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_glitch();
        test_railcheck();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
